// File: rtl/jt51_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt51_pkg
// Brief    : Shared slot/channel constants, group encodings and config type.
// Revision : 1.0
// ============================================================================
package jt51_pkg;

  localparam int SLOTS    = 32;
  localparam int CHANNELS = 8;

  typedef enum logic [1:0] {
    GRP_M1 = 2'd0,
    GRP_C1 = 2'd1,
    GRP_M2 = 2'd2,
    GRP_C2 = 2'd3
  } grp_e;

  typedef struct packed {
    logic [1:0] rl;
    logic [2:0] con;
  } chcfg_t;

  // Power-up routing sends every channel to both outputs
  localparam chcfg_t c_CFG_RST = '{rl: 2'b11, con: 3'd0};

endpackage
`default_nettype wire

// File: rtl/jt51_sh.sv
`default_nettype none
// ============================================================================
// Module   : jt51_sh
// Brief    : Generic cen-qualified shift delay line; STAGES=0 is a wire.
// Revision : 1.0
// ============================================================================
module jt51_sh #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, cen};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] sh_q [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) sh_q[i] <= '0;
        end else if (cen) begin
          sh_q[0] <= din;
          for (int i = 1; i < STAGES; i++) sh_q[i] <= sh_q[i-1];
        end
      end

      assign dout = sh_q[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/jt51_slotseq.sv
`default_nettype none
// ============================================================================
// Module   : jt51_slotseq
// Brief    : Operator slot sequencer with per-channel routing/algorithm table.
// Revision : 1.0
// ============================================================================
module jt51_slotseq
  import jt51_pkg::*;
#(
  parameter int ACC_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       halt,
  input  logic       restart,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [1:0] cfg_rl,
  input  logic [2:0] cfg_con,
  output logic [4:0] slot,
  output logic       m1_enters,
  output logic       c1_enters,
  output logic       m2_enters,
  output logic       c2_enters,
  output logic       op31_acc,
  output logic       sample,
  output logic [1:0] rl_I,
  output logic [2:0] con_I
);

  logic [4:0] slot_d, slot_q;
  logic       adv_d;
  logic       grp_first_d;
  grp_e       grp_d;
  logic       m1_d, c1_d, m2_d, c2_d, op31_d, sample_d;
  logic       m1_q, c1_q, m2_q, c2_q, op31_q, sample_q;
  chcfg_t     rd_d, rd_q;
  chcfg_t     tab_q [CHANNELS];
  logic [4:0] acc_w;

  always_comb begin
    slot_d = slot_q;
    adv_d  = 1'b0;
    if (restart) begin
      slot_d = 5'd0;
      adv_d  = 1'b1;
    end else if (!halt) begin
      slot_d = slot_q + 5'd1;
      adv_d  = 1'b1;
    end
    grp_d       = grp_e'(slot_d[4:3]);
    grp_first_d = adv_d && (slot_d[2:0] == 3'd0);
    m1_d        = grp_first_d && (grp_d == GRP_M1);
    c1_d        = grp_first_d && (grp_d == GRP_C1);
    m2_d        = grp_first_d && (grp_d == GRP_M2);
    c2_d        = grp_first_d && (grp_d == GRP_C2);
    op31_d      = adv_d && (slot_d == 5'(SLOTS - 1));
    sample_d    = adv_d && (slot_d == 5'd0);
    // Read sees the pre-write table, so a same-edge write returns old data
    rd_d        = tab_q[slot_d[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= 5'(SLOTS - 1);
      m1_q     <= 1'b0;
      c1_q     <= 1'b0;
      m2_q     <= 1'b0;
      c2_q     <= 1'b0;
      op31_q   <= 1'b0;
      sample_q <= 1'b0;
      rd_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) tab_q[i] <= c_CFG_RST;
    end else if (cen) begin
      slot_q   <= slot_d;
      m1_q     <= m1_d;
      c1_q     <= c1_d;
      m2_q     <= m2_d;
      c2_q     <= c2_d;
      op31_q   <= op31_d;
      sample_q <= sample_d;
      rd_q     <= rd_d;
      if (cfg_we) tab_q[cfg_ch] <= '{rl: cfg_rl, con: cfg_con};
    end
  end

  jt51_sh #(
    .WIDTH  (5),
    .STAGES (ACC_DLY)
  ) u_acc_sh (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .din  (rd_q),
    .dout (acc_w)
  );

  assign slot      = slot_q;
  assign m1_enters = m1_q;
  assign c1_enters = c1_q;
  assign m2_enters = m2_q;
  assign c2_enters = c2_q;
  assign op31_acc  = op31_q;
  assign sample    = sample_q;
  assign rl_I      = acc_w[4:3];
  assign con_I     = acc_w[2:0];

endmodule
`default_nettype wire

// File: tb/tb_jt51_slotseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt51_slotseq
// Brief    : Directed scoreboard bench for the slot sequencer.
// Revision : 1.0
// ============================================================================
module tb_jt51_slotseq;

  localparam int ACC_DLY = 2;

  typedef struct packed {
    logic [4:0] slot;
    logic       m1, c1, m2, c2, op31, sample;
    logic [1:0] rl;
    logic [2:0] con;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       halt = 1'b0;
  logic       restart = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = 3'd0;
  logic [1:0] cfg_rl = 2'd0;
  logic [2:0] cfg_con = 3'd0;
  logic [4:0] slot;
  logic       m1_enters, c1_enters, m2_enters, c2_enters, op31_acc, sample;
  logic [1:0] rl_I;
  logic [2:0] con_I;

  jt51_slotseq #(.ACC_DLY(ACC_DLY)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .halt      (halt),
    .restart   (restart),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_rl    (cfg_rl),
    .cfg_con   (cfg_con),
    .slot      (slot),
    .m1_enters (m1_enters),
    .c1_enters (c1_enters),
    .m2_enters (m2_enters),
    .c2_enters (c2_enters),
    .op31_acc  (op31_acc),
    .sample    (sample),
    .rl_I      (rl_I),
    .con_I     (con_I)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  obs_t exp_q[$];

  // Behavioural reference
  logic [4:0] m_slot;
  logic [4:0] m_tab  [8];
  logic [4:0] m_pipe [ACC_DLY+1];
  obs_t       m_out;

  function automatic obs_t dut_obs();
    return {slot, m1_enters, c1_enters, m2_enters, c2_enters,
            op31_acc, sample, rl_I, con_I};
  endfunction

  task automatic model(input logic r, input logic c, input logic h, input logic rs,
                       input logic we, input logic [2:0] ch, input logic [1:0] rl,
                       input logic [2:0] con);
    logic       adv;
    logic [4:0] ns;
    if (r) begin
      m_slot = 5'd31;
      for (int i = 0; i < 8; i++) m_tab[i] = 5'b11_000;
      for (int i = 0; i <= ACC_DLY; i++) m_pipe[i] = 5'd0;
      m_out = '0;
      m_out.slot = 5'd31;
    end else if (c) begin
      adv = rs || !h;
      ns  = rs ? 5'd0 : (h ? m_slot : 5'(m_slot + 5'd1));
      for (int i = ACC_DLY; i >= 1; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = m_tab[ns[2:0]];
      if (we) m_tab[ch] = {rl, con};
      m_slot = ns;
      m_out.slot   = ns;
      m_out.m1     = adv && ns == 5'd0;
      m_out.c1     = adv && ns == 5'd8;
      m_out.m2     = adv && ns == 5'd16;
      m_out.c2     = adv && ns == 5'd24;
      m_out.op31   = adv && ns == 5'd31;
      m_out.sample = adv && ns == 5'd0;
      {m_out.rl, m_out.con} = m_pipe[ACC_DLY];
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step(input string tag, input logic r, input logic c, input logic h,
                      input logic rs, input logic we = 1'b0, input logic [2:0] ch = 3'd0,
                      input logic [1:0] rl = 2'd0, input logic [2:0] con = 3'd0);
    obs_t e;
    rst = r; cen = c; halt = h; restart = rs;
    cfg_we = we; cfg_ch = ch; cfg_rl = rl; cfg_con = con;
    model(r, c, h, rs, we, ch, rl, con);
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, dut_obs(), e);
  endtask

  task automatic run_to(input string tag, input logic [4:0] target);
    for (int k = 0; k < 64 && m_slot != target; k++) step(tag, 0, 1, 0, 0);
  endtask

  initial begin
    step("reset", 1, 1, 0, 0);
    step("reset_nocen", 1, 0, 0, 0);
    chk("reset_slot", 16'(slot), 16'd31);
    chk("reset_acc", 16'({rl_I, con_I}), 16'd0);

    // Two full frames
    step("first_cycle", 0, 1, 0, 0);
    chk("first_flags", 16'({slot, m1_enters, sample}), 16'({5'd0, 1'b1, 1'b1}));
    for (int i = 1; i < 64; i++) step("frame", 0, 1, 0, 0);

    for (int i = 0; i < 8; i++) step("cen_toggle", 0, (i % 2) == 0, 0, 0, 1'b1, 3'd6, 2'b10, 3'd7);

    run_to("to5", 5'd5);
    for (int i = 0; i < 3; i++) step("halt", 0, 1, 1, 0);
    chk("halt_hold", 16'({slot, m1_enters, c1_enters, m2_enters, c2_enters, op31_acc, sample}),
        16'({5'd5, 6'd0}));
    step("halt_release", 0, 1, 0, 0);
    chk("after_halt", 16'(slot), 16'd6);

    run_to("to13", 5'd13);
    step("restart", 0, 1, 0, 1);
    run_to("to13b", 5'd13);
    step("restart_halt", 0, 1, 1, 1);
    chk("restart_halt_flags", 16'({slot, m1_enters, sample}), 16'({5'd0, 1'b1, 1'b1}));

    // Write lands before the ch3 read
    run_to("to1", 5'd1);
    step("wr_ch3", 0, 1, 0, 0, 1'b1, 3'd3, 2'b01, 3'd5);
    step("rd_ch3", 0, 1, 0, 0);
    step("pipe1", 0, 1, 0, 0);
    step("pipe2", 0, 1, 0, 0);
    chk("new_cfg_out", 16'({rl_I, con_I}), 16'({2'b01, 3'd5}));

    // Write colliding with the ch3 read returns the old value
    run_to("to2", 5'd2);
    step("wr_ch3_coll", 0, 1, 0, 0, 1'b1, 3'd3, 2'b10, 3'd6);
    step("coll_pipe1", 0, 1, 0, 0);
    step("coll_pipe2", 0, 1, 0, 0);
    chk("coll_old_out", 16'({rl_I, con_I}), 16'({2'b01, 3'd5}));
    run_to("to3", 5'd3);
    step("next_pipe1", 0, 1, 0, 0);
    step("next_pipe2", 0, 1, 0, 0);
    chk("coll_new_out", 16'({rl_I, con_I}), 16'({2'b10, 3'd6}));

    run_to("to20", 5'd20);
    step("mid_reset", 1, 1, 0, 0);
    chk("mid_reset_state", 16'({slot, m1_enters, c1_enters, m2_enters, c2_enters, op31_acc, sample}),
        16'({5'd31, 6'd0}));
    step("post_reset", 0, 1, 0, 0);
    chk("post_reset_sample", 16'({slot, sample}), 16'({5'd0, 1'b1}));

    for (int i = 0; i < 80; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step("random", 0, r != 0, r[3] & r[2], r == 4'd5, r[0], 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
